rv32_fetch_unit: RTL and testbench
==================================

# rv32_fetch_unit

Instruction-fetch front end of the RV32 core: owns the PC, issues in-order requests on the instruction-memory port, and buffers returned words with their PCs in a small prefetch FIFO. It is the producer side of the IF/ID pipeline register and presents one instruction/PC pair per cycle to it. It honours the decode-side stall and the global redirect (branch/jump/trap flush), discarding in-flight stale responses.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- DEPTH, 2, prefetch FIFO entries = maximum outstanding requests plus buffered words (legal 1..8)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  IF/ID holding; head entry must not be consumed
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0)
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_addr  out  32  word-aligned request address
- imem_rsp_valid  in  1  response valid (in order, ≥1 cycle after acceptance, no backpressure)
- imem_rsp_data  in  32  instruction word
- fetch_valid  out  1  head entry present
- fetch_code  out  32  head instruction; 32'h0000_0013 (addi x0,x0,0) when empty
- fetch_pc  out  32  head PC; 32'h0 when empty

## Operation
- State: pc (next address to request), FIFO of {pc, code}, out_cnt (accepted, not yet returned, live), drop_cnt (accepted before last redirect, still pending). Counters $clog2(DEPTH+1) bits.
- Credit rule: imem_req_valid = !redirect_valid && (fifo_count + out_cnt < DEPTH). Request accepted when valid && ready; then pc <= pc + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), out_cnt++.
- imem_addr = pc continuously; pc is stable while valid && !ready.
- Response with drop_cnt > 0: discarded, drop_cnt--. Otherwise pushed to FIFO with its PC, out_cnt--. Request PCs kept in a parallel PC FIFO or computed from the head PC; either acceptable. Credit rule guarantees no overflow; a push to a full FIFO is an assertion failure.
- Pop: when fetch_valid && !stall at clock edge. Push and pop in same cycle allowed at any occupancy including full.
- Redirect (highest priority): pc <= {redirect_pc[31:2],2'b00}; FIFO emptied; drop_cnt <= drop_cnt + out_cnt − (this cycle's response counted against out_cnt); out_cnt <= 0; no request issued; no pop; the cycle's response is discarded. Redirect overrides stall.
- Back-to-back redirects: each retargets pc; drop accounting accumulates.
- Response with out_cnt == 0 and drop_cnt == 0: illegal, assertion.

## Timing
- Reset values: pc = RESET_PC, FIFO empty, out_cnt = drop_cnt = 0, imem_req_valid = 0 while rst_n low, fetch_valid = 0, fetch_code = 32'h0000_0013, fetch_pc = 0. First request (addr RESET_PC) in first cycle after rst_n deasserts.
- Outputs fetch_* are driven from registered FIFO storage: no combinational path from imem_rsp_* or stall to fetch_*.
- Latency with 1-cycle memory: request in cycle N, response N+1, fetch_valid N+2. Redirect in cycle R: request to redirect_pc in R+1, fetch_valid R+3.
- Steady state with DEPTH ≥ 2, 1-cycle memory, no stall: one instruction per cycle. DEPTH = 1 gives one per two cycles.
- Reset mid-operation clears all state immediately; instruction memory shares rst_n and must also drop pending responses.

## Structure
- rv32_pkg: RV32_NOP = 32'h0000_0013, typedef struct packed {logic [31:0] pc; logic [31:0] code;} fetch_entry_t.
- One sub-module: rv32_fetch_fifo (parameter DEPTH, push/pop/flush, count, registered head, wrap-around pointers).

## Test plan
- Reset, RESET_PC=32'h100, memory ready, 1-cycle latency, no stall -> imem_addr 0x100,0x104,0x108…; fetch_pc 0x100 first valid 2 cycles after reset release, then one per cycle; before that fetch_code = 0x13.
- Stall held 5 cycles with DEPTH=2 -> fetch_pc frozen, at most 2 outstanding+buffered, no imem_req_valid once credits exhausted, resumes in order with no loss or duplication.
- Memory 3-cycle latency, redirect to 0x2000 while 2 requests outstanding -> both stale responses dropped, next fetch_valid shows pc 0x2000, code from address 0x2000.
- Redirect in same cycle as a response and a stall -> response discarded, FIFO empty next cycle, fetch_valid 0, request to redirect_pc next cycle.
- pc near 0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst_n asserted with full FIFO and outstanding requests -> all outputs return to reset values asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 front-end types: the canonical NOP and the IF/ID entry carrying
// an instruction word together with its PC.
package rv32_pkg;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] code;
  } fetch_entry_t;

endpackage

// File: rtl/rv32_fetch_fifo.sv
// Prefetch FIFO of {pc, code} entries with wrap-around pointers, flush and a
// head read straight from registered storage.
module rv32_fetch_fifo
  import rv32_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output fetch_entry_t     head_entry
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: it is only visible while count_q is non-zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_entry = head_valid ? mem_q[rd_ptr_q]
                                 : '{pc: 32'h0000_0000, code: RV32_NOP};

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && (count_q == CNT_W'(DEPTH))));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !flush && (count_q == '0)));

endmodule

// File: rtl/rv32_fetch_unit.sv
// RV32 instruction-fetch front end: owns the PC, issues in-order credit-limited
// requests, buffers returned words and drops responses made stale by a redirect.
module rv32_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        fetch_valid,
  output logic [31:0] fetch_code,
  output logic [31:0] fetch_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0] fifo_count;
  logic             head_valid;
  fetch_entry_t     head_entry;
  fetch_entry_t     push_entry;
  logic             pop, push, req_fire, rsp_drop;
  logic [SUM_W-1:0] in_flight;

  assign pop = head_valid && !stall && !redirect_valid;

  // An entry leaving this cycle frees its slot for a request issued in the
  // same cycle; this is what sustains one instruction per cycle at DEPTH 2.
  assign in_flight = {1'b0, fifo_count} + {1'b0, out_cnt_q} - SUM_W'(pop);

  assign imem_req_valid = rst_n && !redirect_valid && (in_flight < SUM_W'(DEPTH));
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop   = imem_rsp_valid && (drop_cnt_q != '0);
  assign push       = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign push_entry = '{pc: rsp_pc_q, code: imem_rsp_data};

  // Live responses return in request order starting at the last fetch target,
  // so their PC is a running counter rather than a second FIFO.
  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      rsp_pc_d   = {redirect_pc[31:2], 2'b00};
      out_cnt_d  = '0;
      drop_cnt_d = drop_cnt_q + out_cnt_q - CNT_W'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - 1'b1;
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      out_cnt_d = out_cnt_q + CNT_W'(req_fire) - CNT_W'(push);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  rv32_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (fifo_count),
    .head_valid (head_valid),
    .head_entry (head_entry)
  );

  assign fetch_valid = head_valid;
  assign fetch_code  = head_entry.code;
  assign fetch_pc    = head_entry.pc;

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (out_cnt_q == '0) && (drop_cnt_q == '0)));

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Scoreboard bench for rv32_fetch_unit: a reference model predicts the fetch
// stream from the request/redirect history and a negedge monitor compares it.
module tb_rv32_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        fetch_valid;
  logic [31:0] fetch_code, fetch_pc;

  always #5 clk = ~clk;

  rv32_fetch_unit #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .fetch_valid    (fetch_valid),
    .fetch_code     (fetch_code),
    .fetch_pc       (fetch_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] code;
  } exp_t;

  mem_req_t    mem_q[$];
  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  logic [31:0] exp_next = RST_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A13;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_fetch(input int max_cyc, output int waited, output bit ok);
    ok = 1'b0;
    waited = max_cyc;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (fetch_valid) begin
        ok = 1'b1;
        waited = i;
        break;
      end
    end
  endtask

  // Instruction memory: in-order, fixed latency per phase, no backpressure.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        mem_q.delete();
        imem_rsp_valid = 1'b0;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_q[0].addr);
        void'(mem_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
    end
  end

  // Monitor: evaluates what the coming clock edge will do and checks it
  // against the model of sequential fetch from the last reset/redirect target.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        exp_next = RST_PC;
        last_due = 0;
      end else begin
        if (!fetch_valid) begin
          check("empty_code", fetch_code, NOP);
          check("empty_pc", fetch_pc, 32'h0);
        end
        if (redirect_valid) begin
          check("req_during_redirect", {31'b0, imem_req_valid}, 32'd0);
          sb.delete();
          exp_next = {redirect_pc[31:2], 2'b00};
        end else begin
          if (fetch_valid && !stall) begin
            check("fetch_expected", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
              check("fetch_pc", fetch_pc, sb[0].pc);
              check("fetch_code", fetch_code, sb[0].code);
              void'(sb.pop_front());
            end
          end
          if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_addr, exp_next);
            sb.push_back('{pc: exp_next, code: mem_word(exp_next)});
            exp_next = exp_next + 32'd4;
          end
          check("credit_bound", {31'b0, sb.size() <= DEPTH}, 32'd1);
        end
        if (imem_req_valid && imem_req_ready) begin
          int due;
          due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
          last_due = due;
          mem_q.push_back('{addr: imem_addr, due: due});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] frozen;
    int          w;
    bit          ok;
    bit          found;

    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;

    // Reset values, then first-fetch latency and full-rate streaming
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    check("rst_fetch_code", fetch_code, NOP);
    check("rst_fetch_pc", fetch_pc, 32'h0);
    check("rst_addr", imem_addr, RST_PC);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_addr, RST_PC);
    check("first_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    for (int k = 1; k < 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("lat_not_yet_valid", {31'b0, fetch_valid}, 32'd0);
        check("lat_nop_code", fetch_code, NOP);
        check("lat_addr2", imem_addr, RST_PC + 32'd4);
      end else begin
        check("stream_valid", {31'b0, fetch_valid}, 32'd1);
        check("stream_pc", fetch_pc, RST_PC + 32'(4 * (k - 2)));
        check("stream_code", fetch_code, mem_word(RST_PC + 32'(4 * (k - 2))));
      end
    end

    // Stall held five cycles: head frozen, no requests once credits are used
    @(posedge clk);
    #1 stall = 1'b1;
    @(negedge clk);
    frozen = fetch_pc;
    check("stall_valid", {31'b0, fetch_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_frozen_pc", fetch_pc, frozen);
      check("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    @(posedge clk);
    #1 stall = 1'b0;
    repeat (4) @(negedge clk);

    // Randomized ready/stall/redirect at 1- and 3-cycle memory latency
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      lat            = (i < 300) ? 1 : 3;
      imem_req_ready = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom & 32'h0000_FFFF;
    end
    @(posedge clk);
    #1;
    imem_req_ready = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    lat            = 3;
    repeat (10) @(negedge clk);

    // Redirect to 0x2000 with two live requests outstanding at 3-cycle latency
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (mem_q.size() == 2 && !(imem_req_valid && imem_req_ready)) found = 1'b1;
    end
    check("d_two_outstanding", {31'b0, found}, 32'd1);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    @(negedge clk);
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("d_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("d_req_addr", imem_addr, 32'h0000_2000);
    wait_fetch(10, w, ok);
    check("d_fetch_seen", {31'b0, ok}, 32'd1);
    check("d_fetch_latency", 32'(w), 32'd3);
    check("d_fetch_pc", fetch_pc, 32'h0000_2000);
    check("d_fetch_code", fetch_code, mem_word(32'h0000_2000));

    // Redirect coinciding with a response and a stall
    lat = 1;
    repeat (6) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) found = 1'b1;
    end
    check("e_req_seen", {31'b0, found}, 32'd1);
    @(posedge clk);
    #1;
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3002;
    @(negedge clk);
    check("e_rsp_same_cycle", {31'b0, imem_rsp_valid}, 32'd1);
    check("e_no_req", {31'b0, imem_req_valid}, 32'd0);
    @(posedge clk);
    #1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("e_fifo_empty", {31'b0, fetch_valid}, 32'd0);
    check("e_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("e_req_addr", imem_addr, 32'h0000_3000);

    // PC wrap at the top of the address space
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    @(negedge clk);
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("f_addr0", imem_addr, 32'hFFFF_FFF8);
    check("f_valid0", {31'b0, imem_req_valid}, 32'd1);
    @(negedge clk);
    check("f_addr1", imem_addr, 32'hFFFF_FFFC);
    check("f_valid1", {31'b0, imem_req_valid}, 32'd1);
    @(negedge clk);
    check("f_addr2", imem_addr, 32'h0000_0000);
    check("f_valid2", {31'b0, imem_req_valid}, 32'd1);
    repeat (8) @(negedge clk);

    // Asynchronous reset with a full FIFO
    @(posedge clk);
    #1 stall = 1'b1;
    repeat (6) @(negedge clk);
    check("g_full_valid", {31'b0, fetch_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("g_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("g_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    check("g_fetch_code", fetch_code, NOP);
    check("g_fetch_pc", fetch_pc, 32'h0);
    check("g_addr", imem_addr, RST_PC);
    stall = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("g_restart_valid", {31'b0, imem_req_valid}, 32'd1);
    check("g_restart_addr", imem_addr, RST_PC);
    wait_fetch(10, w, ok);
    check("g_fetch_seen", {31'b0, ok}, 32'd1);
    check("g_fetch_latency", 32'(w), 32'd1);
    check("g_fetch_pc0", fetch_pc, RST_PC);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
